// File: rtl/irq_pending_ctrl_if.sv
// Handshake bundle between the interrupt pending controller and its consumer.
interface irq_pending_ctrl_if #(
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned ID_W    = 2,
   parameter int unsigned MISS_W  = 8
);
   logic                enable;
   logic [NUM_SRC-1:0]  irq_src;
   logic [NUM_SRC-1:0]  irq_mask;
   logic                ack;
   logic                clear_miss;
   logic                irq_out;
   logic [ID_W-1:0]     irq_id;
   logic [NUM_SRC-1:0]  pending;
   logic [MISS_W-1:0]   miss_cnt;

   // Consumer / system side: drives sources and ack, observes the request.
   modport master (
      output enable, irq_src, irq_mask, ack, clear_miss,
      input  irq_out, irq_id, pending, miss_cnt
   );

   // Controller side.
   modport slave (
      input  enable, irq_src, irq_mask, ack, clear_miss,
      output irq_out, irq_id, pending, miss_cnt
   );
endinterface

// File: rtl/irq_pending_ctrl.sv
// Captures interrupt pulses as pending bits and presents one prioritised irq at a time.
module irq_pending_ctrl #(
   parameter int unsigned NUM_SRC     = 4,
   parameter int unsigned ID_W        = 2,
   parameter int unsigned HOLDOFF_CYC = 2,
   parameter int unsigned MISS_W      = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   irq_pending_ctrl_if.slave  bus
);

   localparam int unsigned HO_W  = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
   localparam int unsigned SUM_W = MISS_W + 5;
   localparam logic [MISS_W-1:0] MISS_MAX = '1;
   localparam logic [HO_W-1:0]   HO_LOAD  = HO_W'((HOLDOFF_CYC == 0) ? 0 : HOLDOFF_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ASSERT  = 2'd1,
      S_HOLDOFF = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [NUM_SRC-1:0]   r_src_q;
   logic                 r_armed;
   logic [NUM_SRC-1:0]   r_pending;
   logic                 r_irq_out;
   logic [ID_W-1:0]      r_irq_id;
   logic [HO_W-1:0]      r_hold_cnt;
   logic [MISS_W-1:0]    r_miss_cnt;

   logic [NUM_SRC-1:0]   w_edge;
   logic [NUM_SRC-1:0]   w_clr;
   logic [NUM_SRC-1:0]   w_miss;
   logic [NUM_SRC-1:0]   w_pending_nxt;
   logic [SUM_W-1:0]     w_miss_sum;
   logic [MISS_W-1:0]    w_miss_nxt;
   logic                 w_ack_acc;
   logic                 w_any_pend;
   logic [ID_W-1:0]      w_lowest_id;
   logic                 w_irq_out_nxt;
   logic [ID_W-1:0]      w_irq_id_nxt;
   logic [HO_W-1:0]      w_hold_nxt;

   // Rising-edge capture; the first clock after reset only samples the sources,
   // so a level already high at release is not mistaken for a new edge.
   assign w_edge     = bus.irq_src & ~r_src_q & bus.irq_mask
                     & {NUM_SRC{bus.enable & r_armed}};
   assign w_ack_acc  = bus.enable & bus.ack & (r_state == S_ASSERT);
   assign w_any_pend = |r_pending;

   // One-hot clear of the presented source on an accepted ack.
   always_comb begin
      w_clr = '0;
      if (w_ack_acc) begin
         w_clr[r_irq_id] = 1'b1;
      end
   end

   // Pending update: set beats clear; an edge on a still-pending bit is a miss.
   always_comb begin
      w_miss        = w_edge & r_pending & ~w_clr;
      w_pending_nxt = bus.enable ? ((r_pending & ~w_clr) | w_edge) : '0;
   end

   // Saturating miss counter; clear_miss wins over increments, counter holds when disabled.
   always_comb begin
      w_miss_sum = SUM_W'(r_miss_cnt);
      for (int i = 0; i < int'(NUM_SRC); i++) begin
         w_miss_sum = w_miss_sum + SUM_W'(w_miss[i]);
      end
      w_miss_nxt = r_miss_cnt;
      if (bus.enable) begin
         if (bus.clear_miss) begin
            w_miss_nxt = '0;
         end else if (w_miss_sum > SUM_W'(MISS_MAX)) begin
            w_miss_nxt = MISS_MAX;
         end else begin
            w_miss_nxt = MISS_W'(w_miss_sum);
         end
      end
   end

   // Lowest set pending index has highest priority.
   always_comb begin
      w_lowest_id = '0;
      for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
         if (r_pending[i]) begin
            w_lowest_id = ID_W'(i);
         end
      end
   end

   // Source history, pending bits and miss counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_src_q    <= '0;
         r_armed    <= 1'b0;
         r_pending  <= '0;
         r_miss_cnt <= '0;
      end else begin
         r_src_q    <= bus.irq_src;
         r_armed    <= 1'b1;
         r_pending  <= w_pending_nxt;
         r_miss_cnt <= w_miss_nxt;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      if (!bus.enable) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any_pend) begin
                  w_state_nxt = S_ASSERT;
               end
            end
            S_ASSERT: begin
               if (bus.ack) begin
                  w_state_nxt = (HOLDOFF_CYC == 0) ? S_IDLE : S_HOLDOFF;
               end
            end
            S_HOLDOFF: begin
               if (r_hold_cnt == '0) begin
                  w_state_nxt = S_IDLE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // FSM output logic: next values of the registered request, id and holdoff count.
   always_comb begin
      w_irq_out_nxt = r_irq_out;
      w_irq_id_nxt  = r_irq_id;
      w_hold_nxt    = r_hold_cnt;
      if (!bus.enable) begin
         w_irq_out_nxt = 1'b0;
         w_hold_nxt    = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any_pend) begin
                  w_irq_out_nxt = 1'b1;
                  w_irq_id_nxt  = w_lowest_id;
               end
            end
            S_ASSERT: begin
               if (bus.ack) begin
                  w_irq_out_nxt = 1'b0;
                  w_hold_nxt    = HO_LOAD;
               end
            end
            S_HOLDOFF: begin
               w_irq_out_nxt = 1'b0;
               if (r_hold_cnt != '0) begin
                  w_hold_nxt = r_hold_cnt - HO_W'(1);
               end
            end
            default: w_irq_out_nxt = 1'b0;
         endcase
      end
   end

   // Registered request outputs and holdoff counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_irq_out  <= 1'b0;
         r_irq_id   <= '0;
         r_hold_cnt <= '0;
      end else begin
         r_irq_out  <= w_irq_out_nxt;
         r_irq_id   <= w_irq_id_nxt;
         r_hold_cnt <= w_hold_nxt;
      end
   end

   assign bus.irq_out  = r_irq_out;
   assign bus.irq_id   = r_irq_id;
   assign bus.pending  = r_pending;
   assign bus.miss_cnt = r_miss_cnt;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Self-checking bench for irq_pending_ctrl (NUM_SRC=4, HOLDOFF_CYC=2, MISS_W=8).
module tb_irq_pending_ctrl;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   logic [1:0] exp_q[$];
   logic [1:0] exp_id;

   irq_pending_ctrl_if #(.NUM_SRC(4), .ID_W(2), .MISS_W(8)) bus ();

   irq_pending_ctrl #(
      .NUM_SRC(4), .ID_W(2), .HOLDOFF_CYC(2), .MISS_W(8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pops the scoreboard only when the DUT is presenting an irq.
   task automatic pop_and_check_id(input string name);
      checks++;
      if (bus.irq_out !== 1'b1) begin
         errors++;
         $display("FAIL %s_irq_out got %b exp 1", name, bus.irq_out);
      end else if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s_sb_underflow got irq_id %0d exp none", name, bus.irq_id);
      end else begin
         exp_id = exp_q.pop_front();
         if (bus.irq_id !== exp_id) begin
            errors++;
            $display("FAIL %s_irq_id got %0d exp %0d", name, bus.irq_id, exp_id);
         end
      end
   endtask

   task automatic test_reset();
      bus.enable = 1'b1; bus.irq_src = 4'hF; bus.irq_mask = 4'hF;
      bus.ack = 1'b0; bus.clear_miss = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (bus.irq_out !== 1'b0) begin errors++; $display("FAIL rst_irq_out got %b exp 0", bus.irq_out); end
      checks++; if (bus.pending !== 4'h0) begin errors++; $display("FAIL rst_pending got %b exp 0000", bus.pending); end
      checks++; if (bus.miss_cnt !== 8'd0) begin errors++; $display("FAIL rst_miss got %0d exp 0", bus.miss_cnt); end
      checks++; if (bus.irq_id !== 2'd0) begin errors++; $display("FAIL rst_irq_id got %0d exp 0", bus.irq_id); end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      checks++; if (bus.irq_out !== 1'b0) begin errors++; $display("FAIL rst_held_irq_out got %b exp 0", bus.irq_out); end
      checks++; if (bus.pending !== 4'h0) begin errors++; $display("FAIL rst_held_pending got %b exp 0000", bus.pending); end
      bus.irq_src = 4'h0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single();
      bus.irq_src = 4'b0100; exp_q.push_back(2'd2);
      @(negedge clk);
      bus.irq_src = 4'b0000;
      checks++; if (bus.pending !== 4'b0100) begin errors++; $display("FAIL single_pending got %b exp 0100", bus.pending); end
      checks++; if (bus.irq_out !== 1'b0) begin errors++; $display("FAIL single_early_irq got %b exp 0", bus.irq_out); end
      @(negedge clk);
      pop_and_check_id("single");
      bus.ack = 1'b1;
      @(negedge clk);
      bus.ack = 1'b0;
      checks++; if (bus.irq_out !== 1'b0) begin errors++; $display("FAIL single_ack_irq got %b exp 0", bus.irq_out); end
      checks++; if (bus.pending !== 4'b0000) begin errors++; $display("FAIL single_ack_pending got %b exp 0000", bus.pending); end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++; if (bus.irq_out !== 1'b0) begin errors++; $display("FAIL single_holdoff%0d got %b exp 0", c, bus.irq_out); end
      end
      @(negedge clk);
   endtask

   task automatic test_two_sources();
      bus.irq_src = 4'b1010; exp_q.push_back(2'd1); exp_q.push_back(2'd3);
      @(negedge clk);
      bus.irq_src = 4'b0000;
      checks++; if (bus.pending !== 4'b1010) begin errors++; $display("FAIL two_pending got %b exp 1010", bus.pending); end
      @(negedge clk);
      pop_and_check_id("two_first");
      bus.ack = 1'b1;
      @(negedge clk);
      bus.ack = 1'b0;
      checks++; if (bus.pending !== 4'b1000) begin errors++; $display("FAIL two_pending_mid got %b exp 1000", bus.pending); end
      checks++; if (bus.irq_out !== 1'b0) begin errors++; $display("FAIL two_ack_irq got %b exp 0", bus.irq_out); end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++; if (bus.irq_out !== 1'b0) begin errors++; $display("FAIL two_holdoff%0d got %b exp 0", c, bus.irq_out); end
      end
      @(negedge clk);
      pop_and_check_id("two_second");
      bus.ack = 1'b1;
      @(negedge clk);
      bus.ack = 1'b0;
      checks++; if (bus.pending !== 4'b0000) begin errors++; $display("FAIL two_pending_end got %b exp 0000", bus.pending); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_miss_saturate();
      for (int p = 0; p < 300; p++) begin
         bus.irq_src = 4'b0001;
         if (p == 0) exp_q.push_back(2'd0);
         @(negedge clk);
         bus.irq_src = 4'b0000;
         @(negedge clk);
         if (p == 9) begin
            checks++; if (bus.miss_cnt !== 8'd9) begin errors++; $display("FAIL miss_partial got %0d exp 9", bus.miss_cnt); end
         end
      end
      checks++; if (bus.miss_cnt !== 8'd255) begin errors++; $display("FAIL miss_sat got %0d exp 255", bus.miss_cnt); end
      checks++; if (bus.pending !== 4'b0001) begin errors++; $display("FAIL miss_pending got %b exp 0001", bus.pending); end
      pop_and_check_id("miss");
      bus.clear_miss = 1'b1;
      @(negedge clk);
      bus.clear_miss = 1'b0;
      checks++; if (bus.miss_cnt !== 8'd0) begin errors++; $display("FAIL miss_clear got %0d exp 0", bus.miss_cnt); end
      bus.ack = 1'b1;
      @(negedge clk);
      bus.ack = 1'b0;
      checks++; if (bus.pending !== 4'b0000) begin errors++; $display("FAIL miss_ack_pending got %b exp 0000", bus.pending); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_ack_collision();
      bus.irq_src = 4'b0001; exp_q.push_back(2'd0); exp_q.push_back(2'd0);
      @(negedge clk);
      bus.irq_src = 4'b0000;
      @(negedge clk);
      pop_and_check_id("coll_first");
      bus.ack = 1'b1; bus.irq_src = 4'b0001;
      @(negedge clk);
      bus.ack = 1'b0; bus.irq_src = 4'b0000;
      checks++; if (bus.pending !== 4'b0001) begin errors++; $display("FAIL coll_pending got %b exp 0001", bus.pending); end
      checks++; if (bus.irq_out !== 1'b0) begin errors++; $display("FAIL coll_ack_irq got %b exp 0", bus.irq_out); end
      checks++; if (bus.miss_cnt !== 8'd0) begin errors++; $display("FAIL coll_miss got %0d exp 0", bus.miss_cnt); end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++; if (bus.irq_out !== 1'b0) begin errors++; $display("FAIL coll_holdoff%0d got %b exp 0", c, bus.irq_out); end
      end
      @(negedge clk);
      pop_and_check_id("coll_reassert");
      bus.ack = 1'b1;
      @(negedge clk);
      bus.ack = 1'b0;
      checks++; if (bus.pending !== 4'b0000) begin errors++; $display("FAIL coll_end_pending got %b exp 0000", bus.pending); end
      checks++; if (bus.miss_cnt !== 8'd0) begin errors++; $display("FAIL coll_end_miss got %0d exp 0", bus.miss_cnt); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_mask();
      bus.irq_mask = 4'b1110; bus.irq_src = 4'b0001;
      @(negedge clk);
      bus.irq_src = 4'b0000;
      @(negedge clk);
      checks++; if (bus.pending !== 4'b0000) begin errors++; $display("FAIL mask_gate_pending got %b exp 0000", bus.pending); end
      checks++; if (bus.irq_out !== 1'b0) begin errors++; $display("FAIL mask_gate_irq got %b exp 0", bus.irq_out); end
      bus.irq_mask = 4'b1111; bus.irq_src = 4'b0010; exp_q.push_back(2'd1);
      @(negedge clk);
      bus.irq_src = 4'b0000; bus.irq_mask = 4'b0000;
      @(negedge clk);
      checks++; if (bus.pending !== 4'b0010) begin errors++; $display("FAIL mask_keep_pending got %b exp 0010", bus.pending); end
      pop_and_check_id("mask");
      bus.ack = 1'b1;
      @(negedge clk);
      bus.ack = 1'b0; bus.irq_mask = 4'b1111;
      checks++; if (bus.pending !== 4'b0000) begin errors++; $display("FAIL mask_ack_pending got %b exp 0000", bus.pending); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_enable_and_reset();
      bus.irq_src = 4'b0010; exp_q.push_back(2'd1);
      @(negedge clk);
      bus.irq_src = 4'b0000;
      @(negedge clk);
      pop_and_check_id("en");
      bus.enable = 1'b0;
      @(negedge clk);
      checks++; if (bus.irq_out !== 1'b0) begin errors++; $display("FAIL en_off_irq got %b exp 0", bus.irq_out); end
      checks++; if (bus.pending !== 4'b0000) begin errors++; $display("FAIL en_off_pending got %b exp 0000", bus.pending); end
      bus.enable = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (bus.irq_out !== 1'b0) begin errors++; $display("FAIL en_reenable_irq got %b exp 0", bus.irq_out); end
      // build non-reset state: id 3 presented, one miss, then enter holdoff with pending[2]
      bus.irq_src = 4'b1000; exp_q.push_back(2'd3);
      @(negedge clk);
      bus.irq_src = 4'b0000;
      @(negedge clk);
      pop_and_check_id("hr");
      bus.irq_src = 4'b1000;
      @(negedge clk);
      bus.irq_src = 4'b0000;
      @(negedge clk);
      checks++; if (bus.miss_cnt !== 8'd1) begin errors++; $display("FAIL hr_miss got %0d exp 1", bus.miss_cnt); end
      bus.ack = 1'b1;
      @(negedge clk);
      bus.ack = 1'b0; bus.irq_src = 4'b0100;
      @(negedge clk);
      bus.irq_src = 4'b0000;
      checks++; if (bus.pending !== 4'b0100) begin errors++; $display("FAIL hr_pre_pending got %b exp 0100", bus.pending); end
      checks++; if (bus.irq_out !== 1'b0) begin errors++; $display("FAIL hr_pre_irq got %b exp 0", bus.irq_out); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.pending !== 4'b0000) begin errors++; $display("FAIL hr_async_pending got %b exp 0000", bus.pending); end
      checks++; if (bus.miss_cnt !== 8'd0) begin errors++; $display("FAIL hr_async_miss got %0d exp 0", bus.miss_cnt); end
      checks++; if (bus.irq_id !== 2'd0) begin errors++; $display("FAIL hr_async_id got %0d exp 0", bus.irq_id); end
      checks++; if (bus.irq_out !== 1'b0) begin errors++; $display("FAIL hr_async_irq got %b exp 0", bus.irq_out); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      checks++; if (bus.irq_out !== 1'b0) begin errors++; $display("FAIL hr_release_irq got %b exp 0", bus.irq_out); end
      checks++; if (bus.pending !== 4'b0000) begin errors++; $display("FAIL hr_release_pending got %b exp 0000", bus.pending); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", exp_q.size()); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_single();
      test_two_sources();
      test_miss_saturate();
      test_ack_collision();
      test_mask();
      test_enable_and_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end

endmodule
